// File: rtl/oflow_mem_wr_ctrl.sv
// Write controller for the dual-port feature memory: packs two bboxes per row,
// buffers two rows and commits them in one dual-port write cycle.
module oflow_mem_wr_ctrl #(
    parameter int DATA_WIDTH_MEM = 284,
    parameter int BBOX_WIDTH     = 142,
    parameter int ADDR_WIDTH     = 8,
    parameter int RAM_DEPTH      = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BBOX_WIDTH-1:0]     bbox_in,
    input  logic                      bbox_valid,
    input  logic                      frame_last,
    output logic                      bbox_ready,
    output logic [ADDR_WIDTH-1:0]     address_0,
    output logic [ADDR_WIDTH-1:0]     address_1,
    output logic [DATA_WIDTH_MEM-1:0] data_in_0,
    output logic [DATA_WIDTH_MEM-1:0] data_in_1,
    output logic                      csb_0,
    output logic                      csb_1,
    output logic                      web_0,
    output logic                      web_1,
    output logic                      oeb_0,
    output logic                      oeb_1,
    output logic [ADDR_WIDTH:0]       num_rows,
    output logic                      frame_done,
    output logic                      overflow
);

    localparam logic [ADDR_WIDTH:0] ROWS_FULL = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] ROWS_LAST = (ADDR_WIDTH+1)'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                    state_reg, state_next;
    logic [1:0]                slot_reg, slot_next;
    logic [DATA_WIDTH_MEM-1:0] row_a_reg, row_a_next, row_b_reg, row_b_next;
    logic [DATA_WIDTH_MEM-1:0] row_a_fill, row_b_fill;
    logic [ADDR_WIDTH:0]       num_rows_reg, num_rows_next;
    logic                      overflow_reg, overflow_next;
    logic                      frame_done_reg, frame_done_next;
    logic                      bbox_ready_reg, bbox_ready_next;
    logic                      frame_end_reg, frame_end_next;
    logic                      csb_0_reg, csb_0_next, csb_1_reg, csb_1_next;
    logic [ADDR_WIDTH-1:0]     address_0_reg, address_0_next, address_1_reg, address_1_next;
    logic [DATA_WIDTH_MEM-1:0] data_0_reg, data_0_next, data_1_reg, data_1_next;
    logic                      accept;

    assign accept = bbox_valid & bbox_ready_reg & (state_reg == COLLECT);

    // Row contents as they would be with the incoming bbox dropped into its slot.
    always_comb begin
        row_a_fill = row_a_reg;
        row_b_fill = row_b_reg;
        case (slot_reg)
            2'd0:    row_a_fill[DATA_WIDTH_MEM-1:BBOX_WIDTH] = bbox_in;
            2'd1:    row_a_fill[BBOX_WIDTH-1:0]              = bbox_in;
            2'd2:    row_b_fill[DATA_WIDTH_MEM-1:BBOX_WIDTH] = bbox_in;
            default: row_b_fill[BBOX_WIDTH-1:0]              = bbox_in;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        slot_next       = slot_reg;
        row_a_next      = row_a_reg;
        row_b_next      = row_b_reg;
        num_rows_next   = num_rows_reg;
        overflow_next   = overflow_reg;
        frame_done_next = 1'b0;
        bbox_ready_next = bbox_ready_reg;
        frame_end_next  = frame_end_reg;
        csb_0_next      = 1'b1;
        csb_1_next      = 1'b1;
        address_0_next  = address_0_reg;
        address_1_next  = address_1_reg;
        data_0_next     = data_0_reg;
        data_1_next     = data_1_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next      = COLLECT;
                    bbox_ready_next = 1'b1;
                    slot_next       = 2'd0;
                    row_a_next      = '0;
                    row_b_next      = '0;
                    num_rows_next   = '0;
                    overflow_next   = 1'b0;
                    frame_end_next  = 1'b0;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (num_rows_reg == ROWS_FULL) begin
                        // Memory full: swallow the bbox, only frame_last matters.
                        overflow_next = 1'b1;
                        if (frame_last) begin
                            state_next      = DONE;
                            frame_done_next = 1'b1;
                            bbox_ready_next = 1'b0;
                        end
                    end else if (slot_reg == 2'd3 || frame_last) begin
                        csb_0_next     = 1'b0;
                        address_0_next = num_rows_reg[ADDR_WIDTH-1:0];
                        data_0_next    = row_a_fill;
                        if (!slot_reg[1]) begin
                            num_rows_next = num_rows_reg + (ADDR_WIDTH+1)'(1);
                        end else if (num_rows_reg == ROWS_LAST) begin
                            num_rows_next = num_rows_reg + (ADDR_WIDTH+1)'(1);
                            overflow_next = 1'b1;
                        end else begin
                            csb_1_next     = 1'b0;
                            address_1_next = num_rows_reg[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
                            data_1_next    = row_b_fill;
                            num_rows_next  = num_rows_reg + (ADDR_WIDTH+1)'(2);
                        end
                        row_a_next      = '0;
                        row_b_next      = '0;
                        slot_next       = 2'd0;
                        bbox_ready_next = 1'b0;
                        frame_end_next  = frame_last;
                        state_next      = WRITE;
                    end else begin
                        row_a_next = row_a_fill;
                        row_b_next = row_b_fill;
                        slot_next  = slot_reg + 2'd1;
                    end
                end
            end
            WRITE: begin
                if (frame_end_reg) begin
                    state_next      = DONE;
                    frame_done_next = 1'b1;
                end else begin
                    state_next      = COLLECT;
                    bbox_ready_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            slot_reg       <= 2'd0;
            row_a_reg      <= '0;
            row_b_reg      <= '0;
            num_rows_reg   <= '0;
            overflow_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            bbox_ready_reg <= 1'b0;
            frame_end_reg  <= 1'b0;
            csb_0_reg      <= 1'b1;
            csb_1_reg      <= 1'b1;
            address_0_reg  <= '0;
            address_1_reg  <= '0;
            data_0_reg     <= '0;
            data_1_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            slot_reg       <= slot_next;
            row_a_reg      <= row_a_next;
            row_b_reg      <= row_b_next;
            num_rows_reg   <= num_rows_next;
            overflow_reg   <= overflow_next;
            frame_done_reg <= frame_done_next;
            bbox_ready_reg <= bbox_ready_next;
            frame_end_reg  <= frame_end_next;
            csb_0_reg      <= csb_0_next;
            csb_1_reg      <= csb_1_next;
            address_0_reg  <= address_0_next;
            address_1_reg  <= address_1_next;
            data_0_reg     <= data_0_next;
            data_1_reg     <= data_1_next;
        end
    end

    assign bbox_ready = bbox_ready_reg;
    assign address_0  = address_0_reg;
    assign address_1  = address_1_reg;
    assign data_in_0  = data_0_reg;
    assign data_in_1  = data_1_reg;
    assign csb_0      = csb_0_reg;
    assign csb_1      = csb_1_reg;
    assign web_0      = csb_0_reg;
    assign web_1      = csb_1_reg;
    assign oeb_0      = 1'b1;
    assign oeb_1      = 1'b1;
    assign num_rows   = num_rows_reg;
    assign frame_done = frame_done_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_oflow_mem_wr_ctrl.sv
// Directed bench for oflow_mem_wr_ctrl: frames of various lengths, capacity
// overflow, ignored mid-frame start and reset during a write.
module tb_oflow_mem_wr_ctrl;
    localparam int DW = 284;
    localparam int BW = 142;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [BW-1:0] bbox_in = '0;
    logic          bbox_valid = 1'b0;
    logic          frame_last = 1'b0;
    logic          bbox_ready;
    logic [AW-1:0] address_0, address_1;
    logic [DW-1:0] data_in_0, data_in_1;
    logic          csb_0, csb_1, web_0, web_1, oeb_0, oeb_1;
    logic [AW:0]   num_rows;
    logic          frame_done, overflow;

    int total = 0;
    int bad = 0;

    typedef logic [AW+DW-1:0] wr_t;
    wr_t q0[$];
    wr_t q1[$];

    oflow_mem_wr_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .bbox_in(bbox_in),
        .bbox_valid(bbox_valid), .frame_last(frame_last), .bbox_ready(bbox_ready),
        .address_0(address_0), .address_1(address_1),
        .data_in_0(data_in_0), .data_in_1(data_in_1),
        .csb_0(csb_0), .csb_1(csb_1), .web_0(web_0), .web_1(web_1),
        .oeb_0(oeb_0), .oeb_1(oeb_1), .num_rows(num_rows),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Log every write cycle seen on each port.
    always @(negedge clk) begin
        if (!csb_0) q0.push_back({address_0, data_in_0});
        if (!csb_1) q1.push_back({address_1, data_in_1});
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] row(input logic [BW-1:0] hi, input logic [BW-1:0] lo);
        return {hi, lo};
    endfunction

    task automatic exp_wr(input int port, input string tag, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        wr_t e;
        int  n;
        n = (port == 0) ? q0.size() : q1.size();
        chk({tag, "_present"}, DW'(n != 0), DW'(1));
        if (n == 0) return;
        e = (port == 0) ? q0.pop_front() : q1.pop_front();
        $display("write %s: port %0d addr %0d", tag, port, e[AW+DW-1:DW]);
        chk({tag, "_addr"}, DW'(e[AW+DW-1:DW]), DW'(a));
        chk({tag, "_data"}, e[DW-1:0], d);
    endtask

    task automatic send(input logic [BW-1:0] b, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        while (!bbox_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bbox_ready) begin
            chk("ready_timeout", DW'(bbox_ready), DW'(1));
            return;
        end
        bbox_in = b;
        bbox_valid = 1'b1;
        frame_last = last;
        @(posedge clk);
        #1;
        bbox_valid = 1'b0;
        frame_last = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, DW'(frame_done), DW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t e;
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_csb", DW'({csb_0, csb_1, web_0, web_1, oeb_0, oeb_1}), DW'(6'b111111));
        chk("rst_addr", DW'({address_0, address_1}), DW'(0));
        chk("rst_data0", data_in_0, DW'(0));
        chk("rst_data1", data_in_1, DW'(0));
        chk("rst_misc", DW'({bbox_ready, num_rows, frame_done, overflow}), DW'(0));
        @(negedge clk);
        reset = 1'b0;

        // Four bboxes: one dual-port write, exact timing checked.
        @(negedge clk);
        chk("idle_ready", DW'(bbox_ready), DW'(0));
        pulse_start();
        @(negedge clk);
        chk("ready_rise", DW'(bbox_ready), DW'(1));
        send(142'h1, 1'b0);
        send(142'h2, 1'b0);
        send(142'h3, 1'b0);
        send(142'h4, 1'b1);
        @(negedge clk);
        chk("f4_ctl", DW'({csb_0, web_0, csb_1, web_1, oeb_0, oeb_1}), DW'(6'b000011));
        chk("f4_addr0", DW'(address_0), DW'(0));
        chk("f4_data0", data_in_0, row(142'h1, 142'h2));
        chk("f4_addr1", DW'(address_1), DW'(1));
        chk("f4_data1", data_in_1, row(142'h3, 142'h4));
        chk("f4_ready_low", DW'(bbox_ready), DW'(0));
        @(negedge clk);
        chk("f4_ctl_off", DW'({csb_0, csb_1}), DW'(2'b11));
        chk("f4_done", DW'(frame_done), DW'(1));
        chk("f4_rows", DW'(num_rows), DW'(2));
        @(negedge clk);
        chk("f4_done_pulse", DW'(frame_done), DW'(0));
        q0.delete();
        q1.delete();

        // Three bboxes: second row half-filled.
        pulse_start();
        send(142'hA0, 1'b0);
        send(142'hA1, 1'b0);
        send(142'hA2, 1'b1);
        wait_done("f3");
        exp_wr(0, "f3_p0", 8'd0, row(142'hA0, 142'hA1));
        exp_wr(1, "f3_p1", 8'd1, row(142'hA2, 142'h0));
        chk("f3_rows", DW'(num_rows), DW'(2));

        // Nine bboxes with random valid gaps.
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(BW'(32'h100 + i), i == 8);
        end
        wait_done("f9");
        for (int k = 0; k < 2; k++) begin
            exp_wr(0, "f9_p0", AW'(2 * k), row(BW'(32'h100 + 4 * k), BW'(32'h101 + 4 * k)));
            exp_wr(1, "f9_p1", AW'(2 * k + 1), row(BW'(32'h102 + 4 * k), BW'(32'h103 + 4 * k)));
        end
        exp_wr(0, "f9_tail", 8'd4, row(142'h108, 142'h0));
        chk("f9_p1_extra", DW'(q1.size()), DW'(0));
        chk("f9_rows", DW'(num_rows), DW'(5));
        chk("f9_ovf", DW'(overflow), DW'(0));

        // start inside COLLECT must be ignored.
        pulse_start();
        for (int i = 1; i <= 4; i++) send(BW'(i), 1'b0);
        @(negedge clk);
        chk("ms_ready_write", DW'(bbox_ready), DW'(0));
        @(negedge clk);
        chk("ms_ready_back", DW'(bbox_ready), DW'(1));
        pulse_start();
        send(142'h5, 1'b0);
        send(142'h6, 1'b1);
        wait_done("ms");
        exp_wr(0, "ms_p0a", 8'd0, row(142'h1, 142'h2));
        exp_wr(1, "ms_p1a", 8'd1, row(142'h3, 142'h4));
        exp_wr(0, "ms_p0b", 8'd2, row(142'h5, 142'h6));
        chk("ms_rows", DW'(num_rows), DW'(3));

        // 514 bboxes: memory fills at 256 rows, the last two are dropped.
        pulse_start();
        for (int i = 0; i < 514; i++) send(BW'(i + 1), i == 513);
        wait_done("big");
        chk("big_n0", DW'(q0.size()), DW'(128));
        chk("big_n1", DW'(q1.size()), DW'(128));
        if (q0.size() == 128 && q1.size() == 128) begin
            for (int k = 0; k < 128; k++) begin
                e = q0[k];
                if (e[AW+DW-1:DW] != AW'(2 * k)) chk("big_seq0", DW'(e[AW+DW-1:DW]), DW'(2 * k));
                e = q1[k];
                if (e[AW+DW-1:DW] != AW'(2 * k + 1)) chk("big_seq1", DW'(e[AW+DW-1:DW]), DW'(2 * k + 1));
            end
            e = q0[127];
            chk("big_last0_addr", DW'(e[AW+DW-1:DW]), DW'(254));
            chk("big_last0_data", e[DW-1:0], row(BW'(509), BW'(510)));
            e = q1[127];
            chk("big_last1_addr", DW'(e[AW+DW-1:DW]), DW'(255));
            chk("big_last1_data", e[DW-1:0], row(BW'(511), BW'(512)));
        end
        q0.delete();
        q1.delete();
        chk("big_rows", DW'(num_rows), DW'(256));
        chk("big_ovf", DW'(overflow), DW'(1));
        pulse_start();
        @(negedge clk);
        chk("big_clear", DW'({num_rows, overflow}), DW'(0));

        // Reset during the write cycle: no write survives, next frame starts at 0.
        for (int i = 1; i <= 4; i++) send(BW'(32'h50 + i), i == 4);
        reset = 1'b1;
        #1;
        @(negedge clk);
        chk("rw_csb", DW'({csb_0, csb_1, web_0, web_1}), DW'(4'b1111));
        chk("rw_addr", DW'({address_0, address_1}), DW'(0));
        chk("rw_data0", data_in_0, DW'(0));
        chk("rw_misc", DW'({bbox_ready, num_rows, frame_done, overflow}), DW'(0));
        chk("rw_no_write", DW'(q0.size() + q1.size()), DW'(0));
        reset = 1'b0;
        pulse_start();
        send(142'h77, 1'b0);
        send(142'h78, 1'b1);
        wait_done("rw");
        exp_wr(0, "rw_p0", 8'd0, row(142'h77, 142'h78));
        chk("rw_rows", DW'(num_rows), DW'(1));

        @(negedge clk);
        chk("q0_empty", DW'(q0.size()), DW'(0));
        chk("q1_empty", DW'(q1.size()), DW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
